// File: rtl/udi_pkg.sv
// Shared UDI definitions: result-path state encoding and default datapath widths.
package udi_pkg;

  localparam int unsigned UDI_ACC_W = 40;
  localparam int unsigned UDI_LEN_W = 10;
  localparam int unsigned UDI_POW_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } udi_state_e;

endpackage

// File: rtl/udi_sat_add.sv
// Unsigned W-bit adder that clamps to all-ones and flags the overflow.
module udi_sat_add #(
  parameter int unsigned W = 40
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum_c,
  output logic         ovf_c
);

  logic [W:0] full;

  always_comb begin
    full  = {1'b0, a} + {1'b0, b};
    ovf_c = full[W];
    sum_c = ovf_c ? '1 : full[W-1:0];
  end

endmodule

// File: rtl/udi_pow_integ.sv
// Windowed power integrator: sums N power samples with saturation, tracks the
// first maximum and its index, and hands one record out over valid/ready.
module udi_pow_integ
  import udi_pkg::*;
#(
  parameter int unsigned ACC_W = UDI_ACC_W,
  parameter int unsigned LEN_W = UDI_LEN_W
) (
  input  logic                 gclk,
  input  logic                 gresetn,
  input  logic                 start,
  input  logic [LEN_W-1:0]     cfg_len,
  input  logic [UDI_POW_W-1:0] pow_in,
  input  logic                 pow_vld,
  output logic                 busy,
  output logic                 res_vld,
  input  logic                 res_rdy,
  output logic [ACC_W-1:0]     res_sum,
  output logic                 res_sat,
  output logic [UDI_POW_W-1:0] res_peak,
  output logic [LEN_W-1:0]     res_peak_idx
);

  udi_state_e state_q, state_d;
  logic busy_d, res_vld_d;

  logic [LEN_W-1:0]     len_q, cnt_q, peak_idx_q;
  logic [ACC_W-1:0]     acc_q, acc_sum;
  logic [UDI_POW_W-1:0] peak_q;
  logic                 sat_q, acc_ovf;

  logic take_start, take_smp, last_smp, new_peak;

  assign take_start = (state_q == IDLE) && start;
  assign take_smp   = (state_q == ACC) && pow_vld;
  assign last_smp   = take_smp && (cnt_q == len_q);
  assign new_peak   = (cnt_q == '0) || (pow_in > peak_q);

  udi_sat_add #(.W(ACC_W)) u_sat_add (
    .a     (acc_q),
    .b     (ACC_W'(pow_in)),
    .sum_c (acc_sum),
    .ovf_c (acc_ovf)
  );

  always_ff @(posedge gclk or negedge gresetn) begin
    if (!gresetn) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      res_vld <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= busy_d;
      res_vld <= res_vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (take_start) state_d = ACC;
      ACC:     if (last_smp) state_d = HOLD;
      HOLD:    if (res_vld && res_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status flags are registered from the next state so they line up with it.
  always_comb begin
    busy_d    = 1'b0;
    res_vld_d = 1'b0;
    if (state_d != IDLE) busy_d = 1'b1;
    if (state_d == HOLD) res_vld_d = 1'b1;
  end

  always_ff @(posedge gclk or negedge gresetn) begin
    if (!gresetn) begin
      len_q        <= '0;
      cnt_q        <= '0;
      acc_q        <= '0;
      sat_q        <= 1'b0;
      peak_q       <= '0;
      peak_idx_q   <= '0;
      res_sum      <= '0;
      res_sat      <= 1'b0;
      res_peak     <= '0;
      res_peak_idx <= '0;
    end else if (take_start) begin
      len_q      <= cfg_len;
      cnt_q      <= '0;
      acc_q      <= '0;
      sat_q      <= 1'b0;
      peak_q     <= '0;
      peak_idx_q <= '0;
    end else if (take_smp) begin
      acc_q <= acc_sum;
      sat_q <= sat_q | acc_ovf;
      if (new_peak) begin
        peak_q     <= pow_in;
        peak_idx_q <= cnt_q;
      end
      // Result record includes the closing sample itself.
      if (last_smp) begin
        res_sum      <= acc_sum;
        res_sat      <= sat_q | acc_ovf;
        res_peak     <= new_peak ? pow_in : peak_q;
        res_peak_idx <= new_peak ? cnt_q : peak_idx_q;
      end else begin
        cnt_q <= cnt_q + LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_udi_pow_integ.sv
// Directed bench for udi_pow_integ with a sample-queue reference model.
module tb_udi_pow_integ;

  localparam int unsigned ACC_W = 40;
  localparam int unsigned LEN_W = 10;
  localparam logic [63:0] SUM_MAX = (64'd1 << ACC_W) - 64'd1;

  logic gclk = 1'b0;
  logic gresetn = 1'b1;
  logic start = 1'b0;
  logic pow_vld = 1'b0;
  logic res_rdy = 1'b0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic [31:0] pow_in = '0;

  logic busy, res_vld, res_sat;
  logic [ACC_W-1:0] res_sum;
  logic [31:0] res_peak;
  logic [LEN_W-1:0] res_peak_idx;

  int vec_cnt = 0;
  int err_cnt = 0;
  bit chk_en = 1'b0;

  always #5 gclk = ~gclk;

  udi_pow_integ #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .gclk         (gclk),
    .gresetn      (gresetn),
    .start        (start),
    .cfg_len      (cfg_len),
    .pow_in       (pow_in),
    .pow_vld      (pow_vld),
    .busy         (busy),
    .res_vld      (res_vld),
    .res_rdy      (res_rdy),
    .res_sum      (res_sum),
    .res_sat      (res_sat),
    .res_peak     (res_peak),
    .res_peak_idx (res_peak_idx)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collect the window's samples, then derive the record.
  int m_mode;
  int m_n;
  logic [31:0] m_q[$];
  logic e_busy, e_vld, e_sat;
  logic [ACC_W-1:0] e_sum;
  logic [31:0] e_peak;
  logic [LEN_W-1:0] e_idx;

  function automatic void close_window();
    longint unsigned tot = 0;
    int pi = 0;
    foreach (m_q[i]) begin
      tot += 64'(m_q[i]);
      if (m_q[i] > m_q[pi]) pi = i;
    end
    e_sat  = (tot > SUM_MAX);
    e_sum  = ACC_W'(e_sat ? SUM_MAX : tot);
    e_peak = m_q[pi];
    e_idx  = LEN_W'(pi);
  endfunction

  initial begin
    m_mode = 0; m_n = 0;
    e_busy = 1'b0; e_vld = 1'b0; e_sat = 1'b0;
    e_sum = '0; e_peak = '0; e_idx = '0;
    forever begin
      @(posedge gclk or negedge gresetn);
      if (!gresetn) begin
        m_mode = 0;
        m_q.delete();
        e_sat = 1'b0; e_sum = '0; e_peak = '0; e_idx = '0;
      end else begin
        case (m_mode)
          0: if (start) begin
               m_mode = 1;
               m_n = int'(cfg_len) + 1;
               m_q.delete();
             end
          1: if (pow_vld) begin
               m_q.push_back(pow_in);
               if (m_q.size() == m_n) begin
                 close_window();
                 m_mode = 2;
               end
             end
          default: if (res_rdy) m_mode = 0;
        endcase
      end
      e_busy = (m_mode != 0);
      e_vld  = (m_mode == 2);
    end
  end

  initial begin
    forever begin
      @(negedge gclk);
      if (chk_en) begin
        chk("cyc_busy", 64'(busy), 64'(e_busy));
        chk("cyc_res_vld", 64'(res_vld), 64'(e_vld));
        chk("cyc_res_sum", 64'(res_sum), 64'(e_sum));
        chk("cyc_res_sat", 64'(res_sat), 64'(e_sat));
        chk("cyc_res_peak", 64'(res_peak), 64'(e_peak));
        chk("cyc_res_peak_idx", 64'(res_peak_idx), 64'(e_idx));
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge gclk);
  endtask

  task automatic arm(input int len);
    start = 1'b1;
    cfg_len = LEN_W'(len);
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] v);
    pow_vld = 1'b1;
    pow_in = v;
    tick();
    pow_vld = 1'b0;
  endtask

  task automatic accept(input string tag);
    res_rdy = 1'b1;
    tick();
    res_rdy = 1'b0;
    chk({tag, "_post_busy"}, 64'(busy), 64'd0);
    chk({tag, "_post_vld"}, 64'(res_vld), 64'd0);
  endtask

  task automatic chk_res(input string tag, input logic [63:0] s, input logic [31:0] p,
                         input int idx, input bit sat);
    chk({tag, "_vld"}, 64'(res_vld), 64'd1);
    chk({tag, "_sum"}, 64'(res_sum), s);
    chk({tag, "_peak"}, 64'(res_peak), 64'(p));
    chk({tag, "_idx"}, 64'(res_peak_idx), 64'(idx));
    chk({tag, "_sat"}, 64'(res_sat), 64'(sat));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_vld"}, 64'(res_vld), 64'd0);
    chk({tag, "_sum"}, 64'(res_sum), 64'd0);
    chk({tag, "_sat"}, 64'(res_sat), 64'd0);
    chk({tag, "_peak"}, 64'(res_peak), 64'd0);
    chk({tag, "_idx"}, 64'(res_peak_idx), 64'd0);
  endtask

  initial begin
    #1 gresetn = 1'b0;
    chk_en = 1'b1;
    tick(3);
    chk_zero("rst");
    gresetn = 1'b1;
    tick();

    // N=4, tie on 50 keeps index 1; result one cycle after the last sample
    arm(3);
    send(32'd10); send(32'd50); send(32'd20); send(32'd50);
    chk_res("n4", 64'd130, 32'd50, 1, 1'b0);
    accept("n4");

    // N=1 max sample, consumer stalls for 5 cycles
    arm(0);
    send(32'hFFFF_FFFF);
    for (int i = 0; i < 5; i++) begin
      chk("n1_stall_busy", 64'(busy), 64'd1);
      chk_res("n1_stall", 64'h0_FFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
      tick();
    end
    accept("n1");

    // N=1024 all-ones saturates the 40-bit accumulator
    arm(1023);
    for (int i = 0; i < 1024; i++) send(32'hFFFF_FFFF);
    chk_res("n1024", SUM_MAX, 32'hFFFF_FFFF, 0, 1'b1);
    accept("n1024");

    // N=3 with gaps, stray start in ACC, samples and start in HOLD
    arm(2);
    tick(3);
    start = 1'b1; cfg_len = LEN_W'(7);
    tick();
    start = 1'b0;
    tick(3);
    send(32'd5); send(32'd9);
    tick(3);
    send(32'd4);
    pow_vld = 1'b1; pow_in = 32'd1000; start = 1'b1;
    tick(2);
    pow_vld = 1'b0; start = 1'b0;
    chk_res("gaps", 64'd18, 32'd9, 1, 1'b0);
    accept("gaps");

    // Sample coincident with start is not counted
    start = 1'b1; cfg_len = LEN_W'(2); pow_vld = 1'b1; pow_in = 32'd99;
    tick();
    start = 1'b0; pow_vld = 1'b0;
    send(32'd1); send(32'd2); send(32'd3);
    chk_res("coinc", 64'd6, 32'd3, 2, 1'b0);
    accept("coinc");

    // Reset mid-window clears everything immediately, then a fresh window
    arm(3);
    send(32'd11); send(32'd22);
    #2 gresetn = 1'b0;
    #1 chk_zero("midrst");
    tick(2);
    chk_zero("midrst_hold");
    gresetn = 1'b1;
    tick();
    arm(1);
    send(32'd7); send(32'd8);
    chk_res("after_rst", 64'd15, 32'd8, 1, 1'b0);
    accept("after_rst");

    tick(2);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/udi_pow_integ.md
# udi_pow_integ

Windowed power integrator and peak finder that consumes the 32-bit per-sample power word produced by the UDI power stage (I² + Q², optionally halved). Over a software-programmed window of N samples it accumulates total energy, tracks the largest sample and its index, and presents one result record to the UDI result path through a valid/ready handshake. It turns the per-instruction power value into a per-window detection metric without CPU accumulation loops.

## Interface
- ACC_W, 40: accumulator width in bits; saturating.
- LEN_W, 10: window-length field width; N ranges 1..2^LEN_W.
- gclk  in  1  clock, rising edge.
- gresetn  in  1  asynchronous active-low reset.
- start  in  1  single-cycle arm pulse; sampled only in IDLE.
- cfg_len  in  LEN_W  window length minus one (N = cfg_len+1); latched on the accepted start.
- pow_in  in  32  unsigned power sample from the power stage.
- pow_vld  in  1  pow_in valid this cycle; there is no backpressure to the power stage.
- busy  out  1  high in ACC and HOLD.
- res_vld  out  1  result record valid.
- res_rdy  in  1  consumer accepts the record.
- res_sum  out  ACC_W  sum of the N samples, saturated.
- res_sat  out  1  accumulator saturated during this window.
- res_peak  out  32  maximum sample in the window.
- res_peak_idx  out  LEN_W  index 0..N-1 of the first occurrence of res_peak.

## Operation
- States: IDLE, ACC, HOLD.
- IDLE: on start, latch cfg_len into len_q, clear acc, cnt, peak, peak_idx and sat, then go to ACC. A pow_vld in the start cycle is ignored.
- ACC: each pow_vld cycle does the following.
  - acc ← min(acc + pow_in, 2^ACC_W−1); sat is set sticky on overflow.
  - If cnt == 0 or pow_in > peak (strict), then peak ← pow_in and peak_idx ← cnt. Ties keep the earlier index.
  - If cnt == len_q, copy acc/peak/peak_idx/sat (including this sample) into the result registers and go to HOLD. Otherwise cnt++.
- pow_vld low in ACC: no change; gaps are allowed with unbounded length.
- HOLD: res_vld = 1 and result fields are stable.
  - On res_vld && res_rdy, go to IDLE.
  - pow_vld in HOLD is dropped and not counted.
- start outside IDLE is ignored; there is no abort except reset.
- Widths: pow_in is zero-extended to ACC_W before addition. cnt and len_q are LEN_W bits, so cnt never wraps because the exit happens at cnt == len_q.

## Timing
- Reset values: busy=0, res_vld=0, res_sum=0, res_sat=0, res_peak=0, res_peak_idx=0, state=IDLE.
- busy rises the cycle after the accepted start.
- Latency: res_vld rises in the cycle after the edge that accepts the Nth sample, i.e. 1 cycle after the last pow_vld.
- The handshake completes on the edge where res_vld && res_rdy. res_vld falls the following cycle, together with busy.
- The earliest next start is accepted in the first IDLE cycle, so back-to-back windows have a gap of 2 cycles minimum.
- Result fields hold their last values after the handshake until the next window completes.
- gresetn asserted at any time, including mid-window or in HOLD, immediately clears all state and outputs. Deassertion is synchronised externally.

## Structure
- Shared package udi_pkg holds the state enum (IDLE/ACC/HOLD) and the default constants for ACC_W and LEN_W.
- Single module. Optionally instantiate udi_sat_add (ACC_W-bit saturating adder with overflow flag) as the only sub-module.
- Registers use plain always_ff with async active-low reset; the existing mvp register macros are not used because they carry no reset.

## Test plan
- N=4 (cfg_len=3), samples 10, 50, 20, 50 on consecutive cycles -> res_sum=130, res_peak=50, res_peak_idx=1, res_sat=0, res_vld 1 cycle after the 4th sample.
- N=1, single sample 0xFFFFFFFF -> res_sum=0xFFFFFFFF, res_peak_idx=0. Also hold res_rdy low for 5 cycles -> fields stable and busy=1 throughout.
- N=1024, all samples 0xFFFFFFFF (ACC_W=40) -> res_sum=2^40−1, res_sat=1.
- N=3 with pow_vld gaps of 0, 3 and 7 cycles, plus start pulses and pow_vld during ACC and HOLD -> only 3 samples counted, extra start ignored, HOLD samples dropped.
- Start coincident with pow_vld=1, pow_in=99, then samples 1, 2, 3 with N=3 -> 99 excluded, res_sum=6.
- gresetn asserted after 2 of 4 samples, then a new window with N=2 and samples 7, 8 -> all outputs 0 during reset, then res_sum=15, res_peak=8, res_peak_idx=1.
